keypad_pass_scanner: RTL and testbench
======================================

# keypad_pass_scanner

Scans a 4x4 active-low matrix keypad, debounces presses and releases, and encodes each key for the password ROM controller. Every accepted key press updates `pass_input` and emits a single-cycle `pass_load` strobe. The `#` key drives `pass_pound` low instead. The block sits directly upstream of the password ROM controller and drives its `pass_input`, `pass_load` and `pass_pound` inputs.

## Interface
- `SCAN_DIV`, default 1000: clock cycles each column is driven before its rows are sampled. Must be ≥ 4.
- `DEBOUNCE`, default 20000: consecutive stable cycles required to accept a press or a release. Must be ≥ 2.
- `clk`  in  1  system clock, single clock domain.
- `rst`  in  1  reset, asynchronous, active-low.
- `row_n`  in  4  raw keypad rows, active-low (pulled up). Asynchronous to `clk`.
- `col_n`  out  4  column drive, one-hot-low.
- `pass_input`  out  4  code of the last accepted non-`#` key.
- `pass_load`  out  1  one-cycle strobe; `pass_input` is valid in the same cycle.
- `pass_pound`  out  1  active-low; held low while `#` is held (debounced).

## Operation
- Key map, row r / col c:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: * 0 # D
- Codes:
  - Digits map to 4'h0–4'h9.
  - A–D map to 4'hA–4'hD.
  - `*` maps to 4'hE.
  - `#` produces no code; it drives `pass_pound`.
- `row_n` passes through a 2-flop synchronizer. All decisions use the synchronized value `rs`.
- FSM states:
  - **SCAN:**
    - The divider counts 0..SCAN_DIV-1.
    - At terminal count with `rs`==4'b1111: the column advances c0→c1→c2→c3→c0 (col_n 1110→1101→1011→0111→1110).
    - At terminal count with exactly one `rs` bit low: capture row/column, freeze `col_n`, clear the debounce counter, go to DEBOUNCE.
    - At terminal count with two or more bits low: treat as no press and advance the column.
  - **DEBOUNCE:**
    - Each cycle, `rs` equal to the captured pattern increments the counter.
    - Any mismatch returns to SCAN with the divider cleared and the same column still driven.
    - When the counter reaches DEBOUNCE-1, go to PRESSED.
    - On the PRESSED transition, if the key is not `#`: register `pass_input`=code and `pass_load`=1.
    - On the PRESSED transition, if the key is `#`: register `pass_pound`=0. `pass_input` is unchanged and there is no strobe.
  - **PRESSED:**
    - `pass_load` returns to 0 after one cycle.
    - Wait for `rs`==4'b1111, then go to RELEASE with the counter cleared.
  - **RELEASE:**
    - Count consecutive all-ones cycles; any low bit clears the counter and the state remains RELEASE.
    - At DEBOUNCE-1: set `pass_pound`=1, advance to the next column, clear the divider, go to SCAN.
- Holding a key yields exactly one `pass_load`; there is no auto-repeat.
- The next key is accepted only after release is debounced.

## Timing
- Reset values (asynchronous):
  - state=SCAN, `col_n`=4'b1110, divider=0, counter=0.
  - `pass_input`=4'h0, `pass_load`=0, `pass_pound`=1.
- All outputs are registered; there are no combinational paths from `row_n`.
- Synchronizer latency is 2 cycles.
- Press latency:
  - The detecting terminal-count sample occurs in cycle T, with a stable key.
  - `pass_load` is high in cycle T+DEBOUNCE+1, for exactly one cycle.
  - `pass_pound` falls in that same cycle for `#`.
- Release latency:
  - `rs` becomes all-ones in cycle R.
  - `pass_pound` rises in cycle R+DEBOUNCE+1 at the earliest (after one cycle in PRESSED).
- Column change occurs only at divider terminal count in SCAN, or on exit from RELEASE.
- A bounce during DEBOUNCE restarts detection. There is no partial acceptance.
- A second key pressed during PRESSED is ignored; release requires all rows high.
- Reset mid-operation (any state): outputs go to reset values immediately. No pending strobe is emitted after reset deasserts.

## Test plan
- Assert `rst`=0 for 3 cycles, then release. Required: `col_n`=1110, `pass_input`=0, `pass_load`=0, `pass_pound`=1, and with `row_n`=1111 `col_n` rotates every SCAN_DIV cycles (use SCAN_DIV=4, DEBOUNCE=8 throughout).
- Model key `5` (r1 low when c1 driven), held for 100 cycles. Required:
  - `pass_input`=4'h5.
  - Exactly one `pass_load` pulse, 9 cycles after the detecting sample.
  - No further pulse until release plus 8 stable cycles.
- Bounce on key `C`: low for 5 cycles, high 1, low 5, then released. Required: no `pass_load`, and scanning resumes.
- Sequence C, C, C, 1, each with full press and release. Required: four strobes with `pass_input` = C, C, C, 1 respectively.
- Hold `#` for 30 cycles. Required:
  - `pass_pound`=0 from T+9 until 9 cycles after release.
  - `pass_load` stays 0 and `pass_input` is unchanged.
- Two further cases:
  - Keys 1 and 4 held together (same column). Required: no strobe.
  - Assert `rst` mid-DEBOUNCE on key 2. Required: no strobe, `col_n`=1110.

Source files
------------

// File: rtl/keypad_pass_scanner.sv
// 4x4 active-low keypad scanner with press/release debounce, feeding the
// password ROM controller with a key code, a load strobe and a pound flag.
module keypad_pass_scanner #(
    parameter int unsigned SCAN_DIV = 1000,
    parameter int unsigned DEBOUNCE = 20000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] pass_input,
    output logic       pass_load,
    output logic       pass_pound
);

    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned DB_W  = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

    localparam logic [1:0] S_SCAN     = 2'd0;
    localparam logic [1:0] S_DEBOUNCE = 2'd1;
    localparam logic [1:0] S_PRESSED  = 2'd2;
    localparam logic [1:0] S_RELEASE  = 2'd3;

    logic [3:0]       row_s1_q, rs_q;
    logic [1:0]       state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DB_W-1:0]  cnt_q, cnt_d;
    logic [1:0]       col_q, col_d;
    logic [1:0]       row_q, row_d;
    logic [3:0]       col_n_q, col_n_d;
    logic [3:0]       pass_input_q, pass_input_d;
    logic             pass_load_q, pass_load_d;
    logic             pass_pound_q, pass_pound_d;

    logic             one_low;
    logic [1:0]       low_idx;
    logic [3:0]       captured;
    logic             div_tc, cnt_tc, all_high, is_pound;
    logic [3:0]       key_code;

    // Only a single low row is a valid press; anything else is ignored.
    always_comb begin
        one_low = 1'b1;
        low_idx = 2'd0;
        case (rs_q)
            4'b1110: low_idx = 2'd0;
            4'b1101: low_idx = 2'd1;
            4'b1011: low_idx = 2'd2;
            4'b0111: low_idx = 2'd3;
            default: one_low = 1'b0;
        endcase
    end

    always_comb begin
        key_code = 4'h0;
        case ({row_q, col_q})
            4'b00_00: key_code = 4'h1;
            4'b00_01: key_code = 4'h2;
            4'b00_10: key_code = 4'h3;
            4'b00_11: key_code = 4'hA;
            4'b01_00: key_code = 4'h4;
            4'b01_01: key_code = 4'h5;
            4'b01_10: key_code = 4'h6;
            4'b01_11: key_code = 4'hB;
            4'b10_00: key_code = 4'h7;
            4'b10_01: key_code = 4'h8;
            4'b10_10: key_code = 4'h9;
            4'b10_11: key_code = 4'hC;
            4'b11_00: key_code = 4'hE;
            4'b11_01: key_code = 4'h0;
            4'b11_11: key_code = 4'hD;
            default:  key_code = 4'h0;
        endcase
    end

    assign captured = ~(4'b0001 << row_q);
    assign div_tc   = (div_q == DIV_W'(SCAN_DIV - 1));
    assign cnt_tc   = (cnt_q == DB_W'(DEBOUNCE - 1));
    assign all_high = (rs_q == 4'b1111);
    assign is_pound = (row_q == 2'd3) && (col_q == 2'd2);

    always_comb begin
        state_d      = state_q;
        div_d        = div_q;
        cnt_d        = cnt_q;
        col_d        = col_q;
        row_d        = row_q;
        pass_input_d = pass_input_q;
        pass_load_d  = 1'b0;
        pass_pound_d = pass_pound_q;
        case (state_q)
            S_SCAN: begin
                if (div_tc) begin
                    div_d = '0;
                    if (one_low) begin
                        row_d   = low_idx;
                        cnt_d   = '0;
                        state_d = S_DEBOUNCE;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            S_DEBOUNCE: begin
                if (rs_q == captured) begin
                    if (cnt_tc) begin
                        state_d = S_PRESSED;
                        if (is_pound) begin
                            pass_pound_d = 1'b0;
                        end else begin
                            pass_input_d = key_code;
                            pass_load_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + DB_W'(1);
                    end
                end else begin
                    div_d   = '0;
                    state_d = S_SCAN;
                end
            end
            S_PRESSED: begin
                if (all_high) begin
                    cnt_d   = '0;
                    state_d = S_RELEASE;
                end
            end
            default: begin
                if (all_high) begin
                    if (cnt_tc) begin
                        pass_pound_d = 1'b1;
                        col_d        = col_q + 2'd1;
                        div_d        = '0;
                        state_d      = S_SCAN;
                    end else begin
                        cnt_d = cnt_q + DB_W'(1);
                    end
                end else begin
                    cnt_d = '0;
                end
            end
        endcase
        col_n_d = ~(4'b0001 << col_d);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_s1_q     <= 4'hF;
            rs_q         <= 4'hF;
            state_q      <= S_SCAN;
            div_q        <= '0;
            cnt_q        <= '0;
            col_q        <= 2'd0;
            row_q        <= 2'd0;
            col_n_q      <= 4'b1110;
            pass_input_q <= 4'h0;
            pass_load_q  <= 1'b0;
            pass_pound_q <= 1'b1;
        end else begin
            row_s1_q     <= row_n;
            rs_q         <= row_s1_q;
            state_q      <= state_d;
            div_q        <= div_d;
            cnt_q        <= cnt_d;
            col_q        <= col_d;
            row_q        <= row_d;
            col_n_q      <= col_n_d;
            pass_input_q <= pass_input_d;
            pass_load_q  <= pass_load_d;
            pass_pound_q <= pass_pound_d;
        end
    end

    assign col_n      = col_n_q;
    assign pass_input = pass_input_q;
    assign pass_load  = pass_load_q;
    assign pass_pound = pass_pound_q;

endmodule

// File: tb/tb_keypad_pass_scanner.sv
// Directed bench for keypad_pass_scanner with a behavioural 4x4 keypad model.
module tb_keypad_pass_scanner;

    logic       clk;
    logic       rst;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [3:0] pass_input;
    logic       pass_load;
    logic       pass_pound;

    logic [15:0] keys;
    int          n_checks;
    int          n_errors;
    int          load_cnt;
    logic [3:0]  last_code;

    keypad_pass_scanner #(.SCAN_DIV(4), .DEBOUNCE(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .row_n      (row_n),
        .col_n      (col_n),
        .pass_input (pass_input),
        .pass_load  (pass_load),
        .pass_pound (pass_pound)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Key at row r, column c is bit r*4+c; it pulls its row low while its column is driven.
    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
    end

    always @(negedge clk) begin
        if (pass_load === 1'b1) begin
            load_cnt  = load_cnt + 1;
            last_code = pass_input;
        end
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Returns in the first cycle the target column is driven.
    task automatic wait_col(input logic [3:0] target, input string tag);
        int n;
        n = 0;
        while (col_n == target && n < 200) begin tick(1); n++; end
        while (col_n != target && n < 200) begin tick(1); n++; end
        check(tag, 16'(col_n), 16'(target));
    endtask

    task automatic press_key(input int idx, input logic [3:0] col, input string tag);
        wait_col(col, tag);
        keys[idx] = 1'b1;
        tick(20);
        keys = '0;
        tick(15);
    endtask

    initial begin
        logic [3:0] code_seq [4];
        int         idx_seq  [4];
        logic [3:0] col_seq  [4];

        n_checks  = 0;
        n_errors  = 0;
        load_cnt  = 0;
        last_code = 4'h0;
        keys      = '0;
        rst       = 1'b0;

        tick(3);
        check("rst_col_n", 16'(col_n), 16'h000E);
        check("rst_input", 16'(pass_input), 16'h0);
        check("rst_load", 16'(pass_load), 16'h0);
        check("rst_pound", 16'(pass_pound), 16'h1);
        rst = 1'b1;

        // Idle rotation period
        wait_col(4'b1101, "rot_reach_c1");
        tick(3);
        check("rot_hold_c1", 16'(col_n), 16'h000D);
        tick(1);
        check("rot_adv_c2", 16'(col_n), 16'h000B);

        // Key 5 held 100 cycles: strobe exactly T+9
        wait_col(4'b1101, "k5_col");
        keys[5] = 1'b1;
        tick(11);
        check("k5_load_early", 16'(pass_load), 16'h0);
        tick(1);
        check("k5_load_pulse", 16'(pass_load), 16'h1);
        check("k5_input", 16'(pass_input), 16'h5);
        tick(1);
        check("k5_load_end", 16'(pass_load), 16'h0);
        tick(87);
        keys = '0;
        tick(10);
        check("k5_rel_col_hold", 16'(col_n), 16'h000D);
        tick(1);
        check("k5_rel_col_adv", 16'(col_n), 16'h000B);
        check("k5_load_count", 16'(load_cnt), 16'd1);

        // Bouncing C never accepted
        wait_col(4'b0111, "bounce_col");
        keys[11] = 1'b1;
        tick(5);
        keys[11] = 1'b0;
        tick(1);
        keys[11] = 1'b1;
        tick(5);
        keys = '0;
        wait_col(4'b1110, "bounce_resume");
        check("bounce_no_load", 16'(load_cnt), 16'd1);

        // C, C, C, 1
        code_seq = '{4'hC, 4'hC, 4'hC, 4'h1};
        idx_seq  = '{11, 11, 11, 0};
        col_seq  = '{4'b0111, 4'b0111, 4'b0111, 4'b1110};
        for (int k = 0; k < 4; k++) begin
            press_key(idx_seq[k], col_seq[k], "seq_col");
            check("seq_count", 16'(load_cnt), 16'(2 + k));
            check("seq_code", 16'(last_code), 16'(code_seq[k]));
        end

        // # held 30 cycles
        wait_col(4'b1011, "pound_col");
        keys[14] = 1'b1;
        tick(11);
        check("pound_pre", 16'(pass_pound), 16'h1);
        tick(1);
        check("pound_low", 16'(pass_pound), 16'h0);
        check("pound_no_load", 16'(pass_load), 16'h0);
        tick(18);
        keys = '0;
        tick(10);
        check("pound_held", 16'(pass_pound), 16'h0);
        tick(1);
        check("pound_rise", 16'(pass_pound), 16'h1);
        check("pound_load_cnt", 16'(load_cnt), 16'd5);
        check("pound_input", 16'(pass_input), 16'h1);

        // Keys 1 and 4 together
        wait_col(4'b1110, "dual_col");
        keys[0] = 1'b1;
        keys[4] = 1'b1;
        tick(20);
        check("dual_no_load", 16'(load_cnt), 16'd5);
        wait_col(4'b1101, "dual_rotates");
        keys = '0;
        tick(5);

        // Reset in the middle of debouncing key 2
        wait_col(4'b1101, "rstmid_col");
        keys[1] = 1'b1;
        tick(6);
        rst = 1'b0;
        #1;
        check("rstmid_col_n", 16'(col_n), 16'h000E);
        check("rstmid_load", 16'(pass_load), 16'h0);
        check("rstmid_pound", 16'(pass_pound), 16'h1);
        check("rstmid_input", 16'(pass_input), 16'h0);
        tick(2);
        keys = '0;
        rst  = 1'b1;
        tick(20);
        check("rstmid_no_load", 16'(load_cnt), 16'd5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
